// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM arbiter/sequencer.
//   state_e    : sequencer states (idle, address setup, strobe, completion)
//   SRAM_AW/DW : pin-level SRAM address and data widths (1M x 16 device)
//   WORD_BYTES : bytes per requester word
//   half_be    : byte-enable pair belonging to one 16-bit half of a word
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StAck    = 2'd3
  } state_e;

  localparam int unsigned SRAM_AW    = 20;
  localparam int unsigned SRAM_DW    = 16;
  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [1:0] half_be(input logic [WORD_BYTES-1:0] be, input logic half);
    return half ? be[3:2] : be[1:0];
  endfunction

endpackage

// File: rtl/sram_arb_ctrl_if.sv
// Word request channel between one requester and sram_arb_ctrl.
//   req/we/addr/wdata/be : request, held by the requester until gnt
//   gnt                  : one-cycle accept pulse
//   ack/rdata            : one-cycle completion pulse, read data valid with ack
// Modports: master (requester side), slave (controller side).
interface sram_arb_ctrl_if #(
  parameter int unsigned AW = 19
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          gnt;
  logic          ack;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way request arbiter for sram_arb_ctrl.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests from m1/m0
//   take       : the controller accepts the current grant this cycle
//   gnt[1:0]   : one-hot combinational grant (zero when no request)
// Default build: round-robin, the requester not granted last wins a tie.
// SRAM_FIXED_PRIO_EN defined: fixed priority, m0 wins a tie, no pointer state.
module sram_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

`ifdef SRAM_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, take};
`else
  // 0: m0 favoured on a tie, 1: m1 favoured.
  logic prio_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (take && (|req)) begin
      // Granting m0 hands the tie to m1 and vice versa.
      prio_q <= gnt[0];
    end
  end
`endif

endmodule

// File: rtl/sram_arb_ctrl.sv
// Arbiter and access sequencer for a 1M x 16 asynchronous SRAM.
// Two requesters (m0, m1) issue 32-bit word accesses; each is split into two
// 16-bit half-accesses (low half at {addr,0}, high half at {addr,1}), each
// being one SETUP cycle followed by WAIT_CYC STROBE cycles, then one ACK cycle.
//   clk, resetn      : clock, asynchronous active-low reset
//   m0, m1           : request channels (sram_arb_ctrl_if.slave)
//   sram_addr        : SRAM address
//   sram_dq_o/_oe    : write data and pad output enable (tri-state lives above)
//   sram_dq_i        : pad input data
//   sram_*_n         : chip/output/write enables and byte lane strobes
// All outputs are registered. Optional macro SRAM_FIXED_PRIO_EN selects
// fixed m0-first priority instead of round-robin (see sram_rr_arbiter).
module sram_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 1,
  parameter int unsigned AW       = 19
) (
  input  logic               clk,
  input  logic               resetn,
  sram_arb_ctrl_if.slave     m0,
  sram_arb_ctrl_if.slave     m1,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n
);

  localparam int unsigned    CntW    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYC - 1);

  state_e                  state_q, state_d;
  logic                    half_q, half_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic                    lat_we_q, lat_we_d;
  logic [AW-1:0]           lat_addr_q, lat_addr_d;
  logic [31:0]             lat_wdata_q, lat_wdata_d;
  logic [WORD_BYTES-1:0]   lat_be_q, lat_be_d;

  logic [1:0]              req, arb_gnt;
  logic                    take;
  logic                    rd_sample;

  logic [SRAM_AW-1:0]      addr_q, addr_d;
  logic [SRAM_DW-1:0]      dq_o_q, dq_o_d;
  logic                    dq_oe_q, dq_oe_d;
  logic                    ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                    lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic [1:0]              gnt_q, gnt_d, ack_q, ack_d;
  logic [1:0]              hbe_d;
  logic [31:0]             rdata_q;

  assign req  = {m1.req, m0.req};
  assign take = (state_q == StIdle) && (|req);

  sram_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (resetn),
    .req   (req),
    .take  (take),
    .gnt   (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    unique case (state_q)
      StIdle: begin
        if (take) begin
          state_d = StSetup;
          half_d  = 1'b0;
          owner_d = arb_gnt[1];
          if (arb_gnt[1]) begin
            lat_we_d    = m1.we;
            lat_addr_d  = m1.addr;
            lat_wdata_d = m1.wdata;
            lat_be_d    = m1.be;
          end else begin
            lat_we_d    = m0.we;
            lat_addr_d  = m0.addr;
            lat_wdata_d = m0.wdata;
            lat_be_d    = m0.be;
          end
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = CntLoad;
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          if (!half_q) begin
            state_d = StSetup;
            half_d  = 1'b1;
          end else begin
            state_d = StAck;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin values are derived from the next state so they register in step with it.
  always_comb begin
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    gnt_d   = take ? arb_gnt : 2'b00;
    ack_d   = 2'b00;
    hbe_d   = half_be(lat_be_d, half_d);
    if ((state_d == StSetup) || (state_d == StStrobe)) begin
      ce_n_d = 1'b0;
      addr_d = SRAM_AW'({lat_addr_d, half_d});
      if (lat_we_d) begin
        dq_oe_d = 1'b1;
        dq_o_d  = half_d ? lat_wdata_d[31:16] : lat_wdata_d[15:0];
        lb_n_d  = ~hbe_d[0];
        ub_n_d  = ~hbe_d[1];
        // A half with no enabled byte keeps its timing but never strobes WE.
        if (state_d == StStrobe) begin
          we_n_d = ~(|hbe_d);
        end
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
    if (state_d == StAck) begin
      ack_d = owner_d ? 2'b10 : 2'b01;
    end
  end

  assign rd_sample = (state_q == StStrobe) && (cnt_q == '0) && !lat_we_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      half_q      <= 1'b0;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      gnt_q       <= 2'b00;
      ack_q       <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      if (rd_sample) begin
        rdata_q[SRAM_DW*half_q +: SRAM_DW] <= sram_dq_i;
      end
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;
  assign m0.gnt     = gnt_q[0];
  assign m1.gnt     = gnt_q[1];
  assign m0.ack     = ack_q[0];
  assign m1.ack     = ack_q[1];
  // One shared read buffer; only the owner's ack qualifies it.
  assign m0.rdata   = rdata_q;
  assign m1.rdata   = rdata_q;

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Sequencer and two-way arbiter for the board's 1M x 16 asynchronous SRAM (SRAM_DQ/ADDR/LB_N/UB_N/CE_N/OE_N/WE_N pins of fpgaTop).
- Accepts 32-bit word read/write requests from two requesters, m0 (CPU bus bridge) and m1 (DMA/peripheral).
- Splits each request into two 16-bit SRAM half-accesses with programmable wait states.
- Instantiated inside fpgaTop; the DQ tri-state buffer stays at top level.

Parameters:
- WAIT_CYC, 1, strobe cycles per half-access (>=1; 20 ns each at 50 MHz).
- AW, 19, word address width (2^19 x 32-bit words = full 2 MB SRAM).

Ports:
- clk  in  1  system clock (50 MHz domain)
- resetn  in  1  asynchronous active-low reset
- mN_req  in  1  request, N=0,1; held until grant
- mN_we  in  1  1=write, 0=read
- mN_addr  in  AW  word address
- mN_wdata  in  32  write data
- mN_be  in  4  byte enables
- mN_gnt  out  1  one-cycle accept pulse
- mN_ack  out  1  one-cycle completion pulse
- mN_rdata  out  32  read data, valid while mN_ack=1
- sram_addr  out  20  SRAM address
- sram_dq_o  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_i  in  16  pad input
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  SRAM strobes

Behaviour:
- Reset: all *_n strobes=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, all gnt/ack=0, rdata=0, FSM=IDLE, rr pointer=m0. Reset mid-access aborts immediately; no ack is issued.
- All outputs registered.
- FSM: IDLE -> SETUP -> STROBE -> (half=0 ? SETUP : ACK) -> IDLE.
- IDLE:
  - If any req is high at an edge, the arbiter picks a winner.
  - Next state is SETUP with half=0.
  - Winner's gnt=1 for exactly that first SETUP cycle.
  - addr/we/wdata/be latched at the same edge.
  - Requester may drop or change req after the gnt cycle.
- Arbitration: round-robin. When both request, the winner is the one not granted last; the pointer updates on every grant. A single requester always wins.
- SETUP (1 cycle):
  - sram_addr = {latched_addr, half}; ce_n=0.
  - LB/UB from be[1:0] (half 0) or be[3:2] (half 1), active-low.
  - Read: oe_n=0, lb_n=ub_n=0 (be ignored for reads).
  - Write: dq_oe=1, dq_o = wdata[15:0] or wdata[31:16]; we_n=1.
- STROBE (WAIT_CYC cycles, counter):
  - Write: we_n=0, data held; we_n returns to 1 on exit.
  - Read: dq_i sampled into rdata[16*half +: 16] at the edge ending the last strobe cycle.
- ACK (1 cycle): owner's ack=1, rdata valid; ce_n=1, oe_n=1, dq_oe=0.
- Cycle timing (gnt cycle = cycle 0): half1 SETUP at cycle WAIT_CYC+1; ack at cycle 2*WAIT_CYC+2; next gnt no earlier than cycle 2*WAIT_CYC+4.
- Write half with both byte enables 0: SETUP/STROBE still run for fixed latency, with we_n held 1.
- be=0 write: no write strobe, ack still issued.
- A new req arriving during a busy access is held off (no gnt) until IDLE.
- Address wrap: not applicable; the full space is mapped.

Optional Feature:
- SRAM_FIXED_PRIO_EN defined: fixed priority, m0 always wins simultaneous requests; rr pointer removed.
- Undefined: round-robin as above.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum (IDLE, SETUP, STROBE, ACK)
  - SRAM_AW=20, SRAM_DW=16
  - WORD_BYTES=4
- Sub-module sram_rr_arbiter: 2-way req -> one-hot grant plus pointer. Also holds the SRAM_FIXED_PRIO_EN variant.

Test Plan:
- Single write then read: m0 writes addr 0x00010, data 0xDEADBEEF, be=4'hF. Required: SRAM model holds 0xBEEF at 0x00020 and 0xDEAD at 0x00021. m0 read of the same address returns 0xDEADBEEF with ack at gnt+4 cycles (WAIT_CYC=1).
- Byte enables: pre-write 0x11223344, then write 0xAABBCCDD with be=4'b0101. Readback is 0x11BB33DD. we_n low only while the matching lb_n/ub_n is low.
- Arbitration: m0 and m1 hold req continuously for 6 accesses. Grants alternate m0,m1,m0,m1,m0,m1. With SRAM_FIXED_PRIO_EN, all 6 go to m0 while m0_req stays high.
- Wait states: WAIT_CYC=3 read. we_n stays 1 and oe_n=0 for 4 cycles per half. ack at gnt+8. Sampled data matches the model value.
- Reset mid-access: assert resetn=0 during the STROBE of half 1 of a write. All strobes go high asynchronously; no ack. After release, the next m1 request is granted normally.
- be=0 write: ack at gnt+4, we_n never asserted, SRAM contents unchanged.
